pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the pipelined core, replacing the inline PC update of the single-cycle datapath. It holds the fetch PC and selects the next PC from five sources: sequential, branch, jump, return and pipeline flush. It also supports stall. It adds a return-address stack so that call/return pairs redirect without a register read. It sits between the control/execute stages, which produce the redirect requests, and the fetch unit, which consumes `pc`.

## Interface
- `PC_WIDTH`, 32: width of the PC, in word addresses; the increment is +1 per instruction.
- `IMM_WIDTH`, 16: width of the signed branch offset.
- `ADDR_WIDTH`, 26: width of the jump target field. Must be ≤ `PC_WIDTH`.
- `RAS_DEPTH`, 8: number of return-address stack entries. Must be a power of two and ≥ 2.
- `RESET_PC`, 0: PC value loaded on reset.

Ports (name, direction, width, meaning):
- `clock` input 1: the only clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hold the PC and the stack.
- `flush_valid` input 1: redirect from a later stage.
- `flush_target` input `PC_WIDTH`: flush destination.
- `jump_valid` input 1: unconditional jump.
- `jump_address` input `ADDR_WIDTH`: jump target.
- `call` input 1: qualifies `jump_valid`; pushes the return address.
- `ret` input 1: return; pops the stack.
- `branch_taken` input 1: branch condition met.
- `branch_imm` input `IMM_WIDTH`: signed branch offset.
- `pc` output `PC_WIDTH`: current fetch PC.
- `pc_src` output 3: source that produced the current `pc`.
- `ras_count` output `$clog2(RAS_DEPTH)+1`: number of valid stack entries.
- `ras_overflow` output 1: sticky flag; a push overwrote the oldest entry.
- `ras_underflow` output 1: sticky flag; a pop occurred on an empty stack.

## Operation
- `pc_plus1` = `pc + 1`, modulo 2^`PC_WIDTH`. Wrap from all-ones to 0 is legal and silent.
- Next-PC priority, applied every cycle that is not reset (highest first):
  1. **flush**: `flush_target`. The stack is untouched. `flush_valid` overrides `stall`.
  2. **stall**: hold `pc`. No stack operation occurs. `pc_src` is unchanged.
  3. **ret**:
     - Stack non-empty: next PC is the top entry; pop it.
     - Stack empty: next PC is `pc_plus1` and `ras_underflow` is set.
     - `pc_src` = RET in both cases.
  4. **jump**: next PC is `jump_address` zero-extended to `PC_WIDTH`.
     - If `call` is also high, push `pc_plus1`.
  5. **branch**: next PC is `pc_plus1 + sign_extend(branch_imm)`, truncated to `PC_WIDTH`.
  6. **seq**: next PC is `pc_plus1`.
- `call` without `jump_valid` is ignored.
- `call` together with `ret`: `ret` wins and there is no push.
- Return stack behaviour:
  - Circular buffer with a top pointer.
  - Push while `ras_count == RAS_DEPTH` overwrites the oldest entry. The count stays at `RAS_DEPTH` and `ras_overflow` is set.
  - Pop decrements the count, saturating at 0.
- `ras_overflow` and `ras_underflow` clear only on `reset`.

## Timing
- Next PC is combinational from the inputs and registered on the `clock` edge. A redirect request in cycle N appears on `pc` in cycle N+1.
- `pc_src` is registered alongside `pc` and reflects the winning source.
- The stack top is readable combinationally. A push or pop takes effect at the same edge as the PC update, so back-to-back call→ret returns the address pushed one cycle earlier.
- Reset (synchronous, may arrive mid-stream, overrides everything):
  - `pc` = `RESET_PC`, `pc_src` = SEQ.
  - `ras_count` = 0, stack pointer = 0.
  - `ras_overflow` = `ras_underflow` = 0.
  - Stack contents are don't-care.
- The first cycle after reset deassertion fetches `RESET_PC`.

## Structure
- Package `pc_pkg`:
  - enum `npc_src_t` (3 bits): SEQ=0, BRANCH=1, JUMP=2, RET=3, FLUSH=4.
  - Default width constants.
- Sub-module `return_stack`, parametrised by `PC_WIDTH` and `RAS_DEPTH`.
  - Inputs: `clock`, `reset`, `push`, `pop`, `push_data`.
  - Outputs: `top`, `count`, `overflow`, `underflow`.
- `pc_sequencer` keeps the priority mux and the PC register.

## Test plan
- **Reset and sequential run**: `RESET_PC`=0x100, reset for 2 cycles, then idle 3 cycles → `pc` = 0x100, 0x101, 0x102; `pc_src`=SEQ.
- **Branch**: at `pc`=0x10, `branch_taken`=1, `branch_imm`=-3 (0xFFFD) → next `pc`=0x0E.
  - Then `branch_imm`=0x7FFF at `pc`=0xFFFFFFF0 → next `pc`=0x00007FF0 (wrap).
- **Call/return**: at `pc`=0x20, `jump_valid`+`call` with `jump_address`=0x400 → `pc`=0x400, `ras_count`=1.
  - Next cycle `ret` → `pc`=0x21, `ras_count`=0, `pc_src`=RET.
- **Overflow/underflow**, `RAS_DEPTH`=8: 9 calls from `pc` values 0x0..0x8 → `ras_overflow`=1, `ras_count`=8.
  - 8 rets return 0x9, 0x8, …, 0x2.
  - A 9th ret → `pc` = `pc_plus1`, `ras_underflow`=1.
- **Priority**: `flush_valid`(0x300) + `stall` + `ret` + `jump_valid` together → `pc`=0x300 and the stack is unchanged.
  - `stall` + `jump_valid` → `pc` held for as long as `stall` is high.
- **Reset mid-operation**: reset asserted during a call with `ras_count`=3 → next cycle `pc`=`RESET_PC`, `ras_count`=0, both flags 0, and no push is recorded.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter sequencer.
package pc_pkg;

  // Source that produced the current fetch PC
  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_RET    = 3'd3,
    SRC_FLUSH  = 3'd4
  } npc_src_t;

  localparam int unsigned PC_WIDTH_DEF   = 32;
  localparam int unsigned IMM_WIDTH_DEF  = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 26;
  localparam int unsigned RAS_DEPTH_DEF  = 8;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with saturating count and sticky error flags.
// Ports: clock, reset (sync, active-high), push/pop/push_data in;
//        top (combinational top entry), count, overflow, underflow out.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_WIDTH-1:0]          push_data,
  output logic [PC_WIDTH-1:0]          top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  // ptr points at the next free slot; when full it points at the oldest entry
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                do_push;

  // Pop wins if both are requested
  assign do_push = push && !pop;

  // Pointer, count and flag update
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (pop) begin
      if (cnt_q != CNT_W'(0)) begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (do_push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q == CNT_W'(RAS_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem_q[ptr_q] <= push_data;
    end
  end

  assign top       = mem_q[ptr_q - PTR_W'(1)];
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with prioritised next-PC selection and return-address stack.
// Ports: clock, reset (sync, active-high), stall, flush/jump/call/ret/branch
//        requests in; pc, pc_src, ras_count, ras_overflow, ras_underflow out.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned IMM_WIDTH  = IMM_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned RAS_DEPTH  = RAS_DEPTH_DEF,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush_valid,
  input  logic [PC_WIDTH-1:0]         flush_target,
  input  logic                        jump_valid,
  input  logic [ADDR_WIDTH-1:0]       jump_address,
  input  logic                        call,
  input  logic                        ret,
  input  logic                        branch_taken,
  input  logic [IMM_WIDTH-1:0]        branch_imm,
  output logic [PC_WIDTH-1:0]         pc,
  output logic [2:0]                  pc_src,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  npc_src_t            src_q, src_d;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] imm_sext;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_push;
  logic                ras_pop;

  assign pc_plus1 = pc_q + PC_WIDTH'(1);
  assign imm_sext = PC_WIDTH'($signed(branch_imm));

  // Next-PC priority: flush > stall > ret > jump > branch > seq
  always_comb begin
    pc_d     = pc_q;
    src_d    = src_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (flush_valid) begin
      pc_d  = flush_target;
      src_d = SRC_FLUSH;
    end else if (stall) begin
      pc_d  = pc_q;
    end else if (ret) begin
      ras_pop = 1'b1;
      src_d   = SRC_RET;
      pc_d    = (ras_count != '0) ? ras_top : pc_plus1;
    end else if (jump_valid) begin
      pc_d     = PC_WIDTH'(jump_address);
      src_d    = SRC_JUMP;
      ras_push = call;
    end else if (branch_taken) begin
      pc_d  = pc_plus1 + imm_sext;
      src_d = SRC_BRANCH;
    end else begin
      pc_d  = pc_plus1;
      src_d = SRC_SEQ;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= PC_WIDTH'(RESET_PC);
      src_q <= SRC_SEQ;
    end else begin
      pc_q  <= pc_d;
      src_q <= src_d;
    end
  end

  return_stack #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign pc     = pc_q;
  assign pc_src = src_q;

endmodule
